// File: rtl/instr_fetch.sv
// Single-outstanding-request instruction fetch unit with a one-entry output
// buffer, redirect handling and discard of stale memory responses.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o
);

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL   = RESET_PC & PC_ALIGN_MASK;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] target;

  assign target = redirect_pc_i & PC_ALIGN_MASK;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          // A response arriving with the redirect belongs to the old PC.
          pc_d    = target;
          state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
        end else if (imem_rvalid_i) begin
          instr_d  = imem_rdata_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = ST_REQ;
        end else if (valid_q && instr_ready_i) begin
          valid_d = 1'b0;
          pc_d    = pc_out_q + 32'd4;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          pc_d = target;
        end
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC_AL;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req_o    = ~rst_i & ((state_q == ST_REQ) | (state_q == ST_DROP));
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign opcode_o      = instr_q[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed per-cycle vector table, a RESET_PC=0x8000_0000
// reset-in-DROP sequence, and random traffic against a behavioural fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, rvalid, redir, valid, ready;
  logic [31:0] addr, rdata, rpc, instr, pco;
  logic [6:0]  opc;

  logic        h_rst, h_req, h_rvalid, h_redir, h_valid, h_ready;
  logic [31:0] h_addr, h_rdata, h_rpc, h_instr, h_pco;
  logic [6:0]  h_opc;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redir),
    .redirect_pc_i(rpc), .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(instr), .pc_o(pco), .opcode_o(opc)
  );

  instr_fetch #(.RESET_PC(32'h8000_0000)) dut_hi (
    .clk_i(clk), .rst_i(h_rst), .imem_req_o(h_req), .imem_addr_o(h_addr),
    .imem_rvalid_i(h_rvalid), .imem_rdata_i(h_rdata), .redirect_i(h_redir),
    .redirect_pc_i(h_rpc), .instr_valid_o(h_valid), .instr_ready_i(h_ready),
    .instr_o(h_instr), .pc_o(h_pco), .opcode_o(h_opc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rd,
                              input logic rr, input logic [31:0] rp, input logic rdy,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.rvalid = rv; v.rdata = rd; v.redir = rr; v.rpc = rp; v.ready = rdy;
    v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic hchk(input string nm, input logic eq, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    chk({nm, "_req"},   {31'd0, h_req},   {31'd0, eq});
    chk({nm, "_addr"},  h_addr,           ea);
    chk({nm, "_valid"}, {31'd0, h_valid}, {31'd0, ev});
    chk({nm, "_instr"}, h_instr,          ei);
    chk({nm, "_pc"},    h_pco,            ep);
  endtask

  // Behavioural model: a buffered instruction, a pending discard, and the fetch PC.
  logic        m_buf, m_drop;
  logic [31:0] m_pc, m_instr, m_pco;
  // Environment memory: one accepted request, answered after lat cycles.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    rst = 1'b1; rvalid = 1'b0; rdata = '0; redir = 1'b0; rpc = '0; ready = 1'b0;
    h_rst = 1'b1; h_rvalid = 1'b0; h_rdata = '0; h_redir = 1'b0; h_rpc = '0; h_ready = 1'b0;

    tbl.push_back(mk(1,0,32'h0,0,32'h0,0,              0,32'h0,0,32'h13,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              1,32'h0,0,32'h13,32'h0));
    tbl.push_back(mk(0,1,32'h33,0,32'h0,1,             1,32'h0,0,32'h13,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,32'h0,1,32'h33,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              1,32'h4,0,32'h33,32'h0));
    tbl.push_back(mk(0,1,32'h93,0,32'h0,0,             1,32'h4,0,32'h33,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,1,32'hDEADBEEF,0,32'h0,0,       0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,32'h4,1,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,1,32'h103,0,            1,32'h8,0,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              1,32'h100,0,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              1,32'h100,0,32'h93,32'h4));
    tbl.push_back(mk(0,1,32'hBAD00013,0,32'h0,0,       1,32'h100,0,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              1,32'h100,0,32'h93,32'h4));
    tbl.push_back(mk(0,1,32'h113,0,32'h0,0,            1,32'h100,0,32'h93,32'h4));
    tbl.push_back(mk(0,0,32'h0,1,32'h200,1,            0,32'h100,1,32'h113,32'h100));
    tbl.push_back(mk(0,1,32'hCAFE0013,1,32'h304,0,     1,32'h200,0,32'h113,32'h100));
    tbl.push_back(mk(0,1,32'h213,0,32'h0,0,            1,32'h304,0,32'h113,32'h100));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,32'h304,1,32'h213,32'h304));
    tbl.push_back(mk(0,0,32'h0,1,32'h400,0,            1,32'h308,0,32'h213,32'h304));
    tbl.push_back(mk(0,0,32'h0,1,32'h502,0,            1,32'h400,0,32'h213,32'h304));
    tbl.push_back(mk(0,1,32'hBAD10000,0,32'h0,0,       1,32'h500,0,32'h213,32'h304));
    tbl.push_back(mk(0,1,32'h37,0,32'h0,0,             1,32'h500,0,32'h213,32'h304));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,32'h500,1,32'h37,32'h500));
    tbl.push_back(mk(0,1,32'hBAD20000,1,32'hFFFFFFFF,0,1,32'h504,0,32'h37,32'h500));
    tbl.push_back(mk(0,1,32'h6F,0,32'h0,0,             1,32'hFFFFFFFC,0,32'h37,32'h500));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,1,              0,32'hFFFFFFFC,1,32'h6F,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,32'h0,0,32'h0,0,              0,32'h0,0,32'h6F,32'hFFFFFFFC));
    tbl.push_back(mk(0,1,32'hB3,0,32'h0,0,             1,32'h0,0,32'h13,32'h0));
    tbl.push_back(mk(0,0,32'h0,0,32'h0,0,              0,32'h0,1,32'hB3,32'h0));

    @(posedge clk); #1;
    @(posedge clk); #1;

    // Directed per-cycle table
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; rvalid = tbl[i].rvalid; rdata = tbl[i].rdata;
      redir = tbl[i].redir; rpc = tbl[i].rpc; ready = tbl[i].ready;
      #1;
      chk($sformatf("tbl%0d_req", i),    {31'd0, req},   {31'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i),   addr,           tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i),  {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_instr", i),  instr,          tbl[i].e_instr);
      chk($sformatf("tbl%0d_pc", i),     pco,            tbl[i].e_pc);
      chk($sformatf("tbl%0d_opcode", i), {25'd0, opc},   {25'd0, tbl[i].e_instr[6:0]});
      @(posedge clk); #1;
    end

    // Reset in DROP with a non-zero RESET_PC
    hchk("hi_rst", 0, 32'h8000_0000, 0, 32'h13, 32'h0);
    @(posedge clk); #1;
    h_rst = 1'b0; #1;
    hchk("hi_first", 1, 32'h8000_0000, 0, 32'h13, 32'h0);
    @(posedge clk); #1;
    h_rvalid = 1'b1; h_rdata = 32'h0000_0013; #1;
    hchk("hi_resp", 1, 32'h8000_0000, 0, 32'h13, 32'h0);
    @(posedge clk); #1;
    h_rvalid = 1'b0; h_ready = 1'b1; h_redir = 1'b1; h_rpc = 32'h1000; #1;
    hchk("hi_hold", 0, 32'h8000_0000, 1, 32'h13, 32'h8000_0000);
    @(posedge clk); #1;
    h_ready = 1'b0; h_redir = 1'b1; h_rpc = 32'h2000; #1;
    hchk("hi_req", 1, 32'h1000, 0, 32'h13, 32'h8000_0000);
    @(posedge clk); #1;
    h_redir = 1'b0; h_rst = 1'b1; #1;
    hchk("hi_drop_rst", 0, 32'h2000, 0, 32'h13, 32'h8000_0000);
    @(posedge clk); #1;
    h_rst = 1'b0; #1;
    hchk("hi_post_rst", 1, 32'h8000_0000, 0, 32'h13, 32'h0);

    // Random traffic against the model
    rst = 1'b1; rvalid = 1'b0; redir = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_buf = 1'b0; m_drop = 1'b0; m_pc = 32'h0; m_instr = 32'h13; m_pco = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      logic        e_req;
      logic [31:0] tgt;
      rst    = ($urandom_range(0, 199) == 0);
      rvalid = mem_busy && (mem_cnt == 0);
      rdata  = rvalid ? mem_word(mem_addr) : $urandom;
      redir  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | {28'd0, 4'($urandom)};
        default: rpc = {20'd0, 12'($urandom)};
      endcase
      ready  = ($urandom_range(0, 2) != 0);
      #1;
      e_req = !rst && !m_buf;
      chk("rnd_req",    {31'd0, req},   {31'd0, e_req});
      chk("rnd_addr",   addr,           m_pc);
      chk("rnd_valid",  {31'd0, valid}, {31'd0, m_buf});
      chk("rnd_instr",  instr,          m_instr);
      chk("rnd_pc",     pco,            m_pco);
      chk("rnd_opcode", {25'd0, opc},   {25'd0, m_instr[6:0]});

      if (rst) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        if (rvalid) mem_busy = 1'b0;
        else mem_cnt--;
      end else if (e_req) begin
        mem_busy = 1'b1;
        mem_addr = m_pc;
        mem_cnt  = $urandom_range(0, 3);
      end

      tgt = {rpc[31:2], 2'b00};
      if (rst) begin
        m_buf = 1'b0; m_drop = 1'b0; m_pc = 32'h0; m_instr = 32'h13; m_pco = 32'h0;
      end else if (m_buf) begin
        if (redir) begin
          m_buf = 1'b0; m_pc = tgt;
        end else if (ready) begin
          m_buf = 1'b0; m_pc = m_pco + 32'd4;
        end
      end else if (m_drop) begin
        if (redir) m_pc = tgt;
        if (rvalid) m_drop = 1'b0;
      end else if (redir) begin
        m_pc = tgt;
        m_drop = !rvalid;
      end else if (rvalid) begin
        m_buf = 1'b1; m_instr = rdata; m_pco = m_pc;
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req_o  output  1  instruction memory read request, held high until response.
REQ-005 SHALL have port imem_addr_o  output  32  word-aligned fetch address, stable while imem_req_o high.
REQ-006 SHALL have port imem_rvalid_i  input  1  memory response valid, one pulse per request.
REQ-007 SHALL have port imem_rdata_i  input  32  fetched instruction word, valid with imem_rvalid_i.
REQ-008 SHALL have port redirect_i  input  1  single-cycle pulse requesting a fetch from a new PC (taken branch/jal/jalr).
REQ-009 SHALL have port redirect_pc_i  input  32  redirect target address.
REQ-010 SHALL have port instr_valid_o  output  1  instr_o/pc_o/opcode_o hold a valid instruction.
REQ-011 SHALL have port instr_ready_i  input  1  downstream decode stage accepts the instruction.
REQ-012 SHALL have port instr_o  output  32  buffered instruction word.
REQ-013 SHALL have port pc_o  output  32  address of instr_o.
REQ-014 SHALL have port opcode_o  output  7  instr_o[6:0], fed to the opcode type decoder.

Function
REQ-015 SHALL implement FSM states REQ (request outstanding), HOLD (instruction buffered, awaiting ready), DROP (outstanding response to be discarded).
REQ-016 SHALL leave reset in state REQ with pc = RESET_PC, so imem_req_o = 1 and imem_addr_o = RESET_PC in the first cycle after rst_i falls.
REQ-017 SHALL support at most one outstanding request; imem_req_o = 1 exactly in states REQ and DROP.
REQ-018 REQ: on imem_rvalid_i, SHALL register imem_rdata_i into instr_o, pc into pc_o, set instr_valid_o the next cycle, and go to HOLD.
REQ-019 HOLD: instr_valid_o = 1 and instr_o/pc_o/opcode_o SHALL stay constant until instr_valid_o && instr_ready_i.
REQ-020 HOLD with handshake: SHALL clear instr_valid_o, set pc = pc_o + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and go to REQ.
REQ-021 Redirect in REQ without imem_rvalid_i: SHALL set pc = {redirect_pc_i[31:2],2'b00} and go to DROP; the pending response is discarded.
REQ-022 Redirect in REQ coincident with imem_rvalid_i: SHALL discard the data, set pc to the target, stay in REQ, and issue the new address next cycle.
REQ-023 DROP: imem_addr_o SHALL show the new target, but the eventual imem_rvalid_i response SHALL be discarded and the FSM SHALL then go to REQ; a further redirect in DROP SHALL only update pc.
REQ-024 Redirect in HOLD, with or without a handshake in the same cycle: SHALL clear instr_valid_o, set pc to the target, and go to REQ; redirect has priority over pc_o + 4.
REQ-025 SHALL force redirect_pc_i[1:0] to 2'b00.
REQ-026 With a 1-cycle memory and ready always high, SHALL sustain one instruction per 3 cycles (REQ, response registered, HOLD/accept).
REQ-027 opcode_o SHALL be combinationally equal to instr_o[6:0]; imem_rvalid_i in HOLD SHALL be ignored.

Reset
REQ-028 When rst_i = 1 at a clock edge, SHALL set state = REQ, pc = RESET_PC, instr_valid_o = 0, instr_o = 32'h0000_0013 (NOP), pc_o = 0; imem_req_o SHALL read 0 while rst_i is high.
REQ-029 Reset mid-operation (any state) SHALL abandon the outstanding request; a stale imem_rvalid_i in the first post-reset cycle SHALL be accepted as the RESET_PC response.

Verification
REQ-030 Reset release, 1-cycle memory returning 32'h0000_0033, ready = 1 -> req at addr 0, instr_valid_o with instr_o = 32'h33, opcode_o = 7'b0110011, pc_o = 0; next req at addr 4.
REQ-031 Backpressure: ready = 0 for 5 cycles in HOLD -> instr_o/pc_o stable and imem_req_o = 0 throughout; first ready cycle -> req at pc_o + 4.
REQ-032 Redirect to 32'h0000_0103 while waiting on a 4-cycle memory -> DROP; old data never appears on instr_valid_o; next fetched pc_o = 32'h0000_0100.
REQ-033 Redirect and handshake in the same HOLD cycle, target 32'h200 -> next imem_addr_o = 32'h200, not pc_o + 4.
REQ-034 pc_o = 32'hFFFF_FFFC accepted -> next imem_addr_o = 32'h0000_0000.
REQ-035 rst_i asserted in DROP, RESET_PC = 32'h8000_0000 -> instr_valid_o = 0; first post-reset imem_addr_o = 32'h8000_0000.
